// File: rtl/param_updown_counter.sv
// Up/down counter with a prescaled step enable, runtime upper limit,
// wrap/saturate/bounce modes, synchronous load and pause.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 10000000,
  parameter int PRE_W    = $clog2(TICK_DIV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir_eff,
  output logic             tick,
  output logic             wrapped,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [1:0]       MODE_WRAP   = 2'b00;
  localparam logic [1:0]       MODE_BOUNCE = 2'b10;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tick;
  logic             r_wrapped;

  logic             w_tick_int;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_dir;
  logic             w_nxt_wrap;

  function automatic logic [WIDTH-1:0] clamp_to_limit(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  assign w_tick_int = en && (r_pre == PRE_LAST);

  // Next count/direction if a step were taken this cycle.
  always_comb begin
    w_nxt_count = r_count;
    w_nxt_dir   = r_dir;
    w_nxt_wrap  = 1'b0;
    if (r_count > limit) begin
      w_nxt_count = limit;
    end else if (mode == MODE_WRAP) begin
      if (r_dir) begin
        if (r_count == limit) begin
          w_nxt_count = '0;
          w_nxt_wrap  = 1'b1;
        end else begin
          w_nxt_count = r_count + ONE;
        end
      end else begin
        if (r_count == '0) begin
          w_nxt_count = limit;
          w_nxt_wrap  = 1'b1;
        end else begin
          w_nxt_count = r_count - ONE;
        end
      end
    end else if (mode == MODE_BOUNCE) begin
      // Direction flips on the step that lands on an endpoint, so dir_eff
      // already points back inward while the endpoint is displayed.
      if (limit == '0) begin
        w_nxt_dir = ~r_dir;
      end else if (r_dir) begin
        if (r_count == limit) begin
          w_nxt_count = limit - ONE;
          w_nxt_dir   = 1'b0;
        end else begin
          w_nxt_count = r_count + ONE;
          w_nxt_dir   = ((r_count + ONE) != limit);
        end
      end else begin
        if (r_count == '0) begin
          w_nxt_count = ONE;
          w_nxt_dir   = 1'b1;
        end else begin
          w_nxt_count = r_count - ONE;
          w_nxt_dir   = (r_count == ONE);
        end
      end
    end else begin
      if (r_dir) begin
        if (r_count != limit) w_nxt_count = r_count + ONE;
      end else begin
        if (r_count != '0) w_nxt_count = r_count - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_dir     <= 1'b1;
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_count   <= clamp_to_limit(load_val, limit);
      r_dir     <= dir;
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_tick    <= w_tick_int;
      r_wrapped <= w_tick_int && w_nxt_wrap;
      if (w_tick_int) r_count <= w_nxt_count;
      if (mode != MODE_BOUNCE) begin
        r_dir <= dir;
      end else if (w_tick_int) begin
        r_dir <= w_nxt_dir;
      end
    end
  end

  assign count   = r_count;
  assign dir_eff = r_dir;
  assign tick    = r_tick;
  assign wrapped = r_wrapped;
  assign at_min  = (r_count == '0);
  assign at_max  = (r_count == limit);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4, TICK_DIV=4): stimulus
// queues expected step results, a monitor checks them on every tick.
`timescale 1ns/1ps
module tb_param_updown_counter;
  localparam int W  = 4;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, dir, load;
  logic [1:0]   mode;
  logic [W-1:0] limit, load_val, count;
  logic         dir_eff, tick, wrapped, at_min, at_max;

  typedef struct packed {
    logic [W-1:0] c;
    logic         d;
    logic         w;
    logic         mn;
    logic         mx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  param_updown_counter #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .limit(limit),
    .load(load), .load_val(load_val), .count(count), .dir_eff(dir_eff),
    .tick(tick), .wrapped(wrapped), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected entry per tick pulse.
  always begin : mon
    exp_t e;
    exp_t act;
    @(posedge clk);
    #1;
    act = {count, dir_eff, wrapped, at_min, at_max};
    if (tick === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: count=%0d with no step expected", count);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL step: got c=%0d d=%b w=%b min=%b max=%b, expected c=%0d d=%b w=%b min=%b max=%b",
                   act.c, act.d, act.w, act.mn, act.mx, e.c, e.d, e.w, e.mn, e.mx);
        end
      end
    end else begin
      n_checks++;
      if (wrapped !== 1'b0) begin
        n_fail++;
        $display("FAIL wrapped_without_tick: got %b, expected 0", wrapped);
      end
    end
  end

  task automatic push(input int c, input bit d, input bit w, input bit mn, input bit mx);
    exp_t e;
    e.c  = c[W-1:0];
    e.d  = d;
    e.w  = w;
    e.mn = mn;
    e.mx = mx;
    sb.push_back(e);
  endtask

  // The tick must land exactly n clock edges after the current negedge.
  task automatic wait_tick(input int n, input string name);
    repeat (n - 1) @(negedge clk);
    chk({name, "_early"}, sb.size(), 1);
    @(negedge clk);
    chk({name, "_late"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic step(input int c, input bit d, input bit w, input bit mn, input bit mx,
                      input string name);
    push(c, d, w, mn, mx);
    wait_tick(TD, name);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'b00; limit = 4'd15;
    load = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    chk("rst_dir_eff", int'(dir_eff), 1);
    chk("rst_at_min", int'(at_min), 1);
    chk("rst_at_max", int'(at_max), 0);
    rst_n = 1'b1;

    // Wrap up through 15 back to 0.
    for (int i = 1; i <= 16; i++)
      step(i % 16, 1'b1, i == 16, i == 16, i == 15, "wrap_up");

    // Wrap down with limit 9.
    limit = 4'd9;
    step(1, 1, 0, 0, 0, "wrapdn_pre");
    step(2, 1, 0, 0, 0, "wrapdn_pre");
    dir = 1'b0;
    step(1, 0, 0, 0, 0, "wrap_dn");
    step(0, 0, 0, 1, 0, "wrap_dn");
    step(9, 0, 1, 0, 1, "wrap_dn");
    step(8, 0, 0, 0, 0, "wrap_dn");

    // Saturate.
    mode = 2'b01; limit = 4'd15; dir = 1'b1;
    for (int c = 9; c <= 15; c++) step(c, 1, 0, 0, c == 15, "sat_up");
    for (int i = 0; i < 5; i++) step(15, 1, 0, 0, 1, "sat_hold");
    dir = 1'b0;
    step(14, 0, 0, 0, 0, "sat_down");

    // Bounce, limit 3, starting from 0; dir input ignored after the load.
    mode = 2'b10; limit = 4'd3; dir = 1'b1; load_val = 4'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0; dir = 1'b0;
    chk("bnc_load_count", int'(count), 0);
    chk("bnc_load_dir", int'(dir_eff), 1);
    chk("bnc_load_tick", int'(tick), 0);
    step(1, 1, 0, 0, 0, "bounce");
    step(2, 1, 0, 0, 0, "bounce");
    step(3, 0, 0, 0, 1, "bounce");
    step(2, 0, 0, 0, 0, "bounce");
    step(1, 0, 0, 0, 0, "bounce");
    step(0, 1, 0, 1, 0, "bounce");
    step(1, 1, 0, 0, 0, "bounce");

    // Bounce, limit 0.
    limit = 4'd0; load_val = 4'd0; dir = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnc0_load_count", int'(count), 0);
    step(0, 0, 0, 1, 1, "bounce_l0");
    step(0, 1, 0, 1, 1, "bounce_l0");
    step(0, 0, 0, 1, 1, "bounce_l0");

    // Load mid-prescale with clamp to limit; prescaler restarts.
    repeat (2) @(negedge clk);
    mode = 2'b00; limit = 4'd10; dir = 1'b1; load_val = 4'd12; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("load_clamp_count", int'(count), 10);
    chk("load_tick", int'(tick), 0);
    chk("load_at_max", int'(at_max), 1);
    limit = 4'd5;
    #1;
    chk("lowered_at_max", int'(at_max), 0);
    step(5, 1, 0, 0, 1, "clamp");

    // Pause mid-prescale for 20 cycles.
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("pause_count", int'(count), 5);
    chk("pause_tick", int'(tick), 0);
    en = 1'b1;
    push(0, 1, 1, 1, 0);
    wait_tick(2, "pause_resume");

    // Reset one cycle before a pending step.
    limit = 4'd15;
    for (int c = 1; c <= 7; c++) step(c, 1, 0, 0, 0, "pre_reset");
    @(negedge clk);
    @(negedge clk);
    dir = 1'b0;
    @(negedge clk);
    chk("prerst_count", int'(count), 7);
    chk("prerst_dir", int'(dir_eff), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_dir", int'(dir_eff), 1);
    dir = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, "after_reset");

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
